// File: rtl/wb_pkg.sv
// Shared constants for the MIPS32 writeback arbiter: source count, field widths,
// named producer ids and the pointer-advance helper.
package wb_pkg;

    localparam int NUM_SRC = 6;
    localparam int SEL_W   = 3;
    localparam int REG_W   = 5;

    localparam logic [SEL_W-1:0] SRC_ALU   = 3'd0;
    localparam logic [SEL_W-1:0] SRC_SHIFT = 3'd1;
    localparam logic [SEL_W-1:0] SRC_HI    = 3'd2;
    localparam logic [SEL_W-1:0] SRC_LO    = 3'd3;
    localparam logic [SEL_W-1:0] SRC_LOAD  = 3'd4;
    localparam logic [SEL_W-1:0] SRC_LINK  = 3'd5;

    localparam logic [SEL_W-1:0] SEL_NONE  = 3'b000;

    typedef logic [SEL_W-1:0]   sel_t;
    typedef logic [REG_W-1:0]   reg_t;
    typedef logic [NUM_SRC-1:0] src_vec_t;

    // Priority moves to the source after the one just granted; the last id wraps to 0.
    function automatic sel_t next_ptr(input sel_t granted);
        sel_t nxt;
        if (granted == SRC_LINK) begin
            nxt = SRC_ALU;
        end else begin
            nxt = granted + 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_pick6.sv
// Combinational rotate-priority encoder: finds the first eligible source
// starting at ptr and wrapping modulo NUM_SRC.
module rr_pick6
    import wb_pkg::*;
(
    input  logic [NUM_SRC-1:0] eligible,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx,
    output logic [NUM_SRC-1:0] onehot
);

    logic [7:0] elig_ext_s;

    assign elig_ext_s = {2'b00, eligible};

    // Walk the six slots in rotated order and keep the first hit.
    always_comb begin
        found  = 1'b0;
        idx    = SEL_NONE;
        onehot = {NUM_SRC{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            logic [3:0] cand;
            cand = {1'b0, ptr} + 4'(i);
            if (cand >= 4'd6) begin
                cand = cand - 4'd6;
            end else begin
                cand = cand;
            end
            if (!found && elig_ext_s[cand[2:0]]) begin
                found = 1'b1;
                idx   = cand[2:0];
            end else begin
                found = found;
            end
        end
        if (found) begin
            onehot = 6'b000001 << idx;
        end else begin
            onehot = {NUM_SRC{1'b0}};
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter for the register-file write port: grants one of six
// writeback producers per cycle and registers grant, mux select, enable and destination.
module wb_arbiter
    import wb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] req,
    input  logic [REG_W-1:0]   wb_addr_0,
    input  logic [REG_W-1:0]   wb_addr_1,
    input  logic [REG_W-1:0]   wb_addr_2,
    input  logic [REG_W-1:0]   wb_addr_3,
    input  logic [REG_W-1:0]   wb_addr_4,
    input  logic [REG_W-1:0]   wb_addr_5,
    input  logic               wb_stall,
    output logic [NUM_SRC-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               wb_en,
    output logic [REG_W-1:0]   wb_addr
);

    logic [NUM_SRC-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               wb_en_q, wb_en_d;
    logic [REG_W-1:0]   wb_addr_q, wb_addr_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;

    logic [NUM_SRC-1:0] eligible_s;
    logic               pick_found_s;
    logic [SEL_W-1:0]   pick_idx_s;
    logic [NUM_SRC-1:0] pick_onehot_s;
    logic [REG_W-1:0]   pick_addr_s;

    // A source granted this cycle is masked so it cannot win twice in a row.
    assign eligible_s = req & ~gnt_q;

    rr_pick6 u_pick (
        .eligible (eligible_s),
        .ptr      (ptr_q),
        .found    (pick_found_s),
        .idx      (pick_idx_s),
        .onehot   (pick_onehot_s)
    );

    // Destination register of the winning source.
    always_comb begin
        pick_addr_s = 5'd0;
        case (pick_idx_s)
            SRC_ALU:   pick_addr_s = wb_addr_0;
            SRC_SHIFT: pick_addr_s = wb_addr_1;
            SRC_HI:    pick_addr_s = wb_addr_2;
            SRC_LO:    pick_addr_s = wb_addr_3;
            SRC_LOAD:  pick_addr_s = wb_addr_4;
            SRC_LINK:  pick_addr_s = wb_addr_5;
            default:   pick_addr_s = 5'd0;
        endcase
    end

    // Next grant state; a $zero destination still takes the slot but never writes.
    always_comb begin
        gnt_d     = {NUM_SRC{1'b0}};
        sel_d     = SEL_NONE;
        wb_en_d   = 1'b0;
        wb_addr_d = 5'd0;
        ptr_d     = ptr_q;
        if (pick_found_s && !wb_stall) begin
            gnt_d     = pick_onehot_s;
            sel_d     = pick_idx_s;
            wb_en_d   = (pick_addr_s != 5'd0);
            wb_addr_d = pick_addr_s;
            ptr_d     = next_ptr(pick_idx_s);
        end else begin
            ptr_d     = ptr_q;
        end
    end

    // Output and pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q     <= {NUM_SRC{1'b0}};
            sel_q     <= SEL_NONE;
            wb_en_q   <= 1'b0;
            wb_addr_q <= 5'd0;
            ptr_q     <= SRC_ALU;
        end else begin
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            ptr_q     <= ptr_d;
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign wb_en   = wb_en_q;
    assign wb_addr = wb_addr_q;

endmodule
